// File: rtl/softmax_out_pkg.sv
// Shared sizes and FSM state type for the softmax output writer.
package softmax_out_pkg;
  localparam int N      = 32;
  localparam int DATA_W = 16;
  localparam int ADDR_W = $clog2(N);
  localparam int SUM_W  = DATA_W + ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/softmax_out_writer_if.sv
// Row-in / monitor-out bundle of the softmax output writer, plus the probe read port.
interface softmax_out_writer_if;
  import softmax_out_pkg::*;

  // i_valid is a one-cycle pulse taken on the edge where o_ready is high;
  // a pulse while o_ready is low is dropped and flagged in o_overrun.
  logic                  i_valid;
  logic [N*DATA_W-1:0]   i_data;
  logic                  o_ready;
  logic                  o_wr_en;
  logic [ADDR_W-1:0]     o_wr_addr;
  logic [DATA_W-1:0]     o_wr_data;
  logic                  o_done;
  logic [SUM_W-1:0]      o_sum;
  logic                  o_overrun;
  logic [ADDR_W-1:0]     i_probe_addr;
  logic [DATA_W-1:0]     o_probe_doutb;
  state_t                dbg_state;

  modport slave (
    input  i_valid, i_data, i_probe_addr,
    output o_ready, o_wr_en, o_wr_addr, o_wr_data, o_done, o_sum,
           o_overrun, o_probe_doutb, dbg_state
  );

  modport master (
    output i_valid, i_data, i_probe_addr,
    input  o_ready, o_wr_en, o_wr_addr, o_wr_data, o_done, o_sum,
           o_overrun, o_probe_doutb, dbg_state
  );
endinterface

// File: rtl/sdp_ram_1r1w.sv
// Simple dual-port RAM: one write port, one registered read port, read-before-write.
module sdp_ram_1r1w #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // No reset anywhere so the array and its output register map onto a block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/softmax_out_writer.sv
// Latches a softmax row, streams it into the output RAM one element per cycle,
// accumulates the element sum and flags completion.
module softmax_out_writer
  import softmax_out_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  softmax_out_writer_if.slave  bus
);
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q;
  logic [N*DATA_W-1:0] buf_q;
  logic [SUM_W-1:0]    sum_q;
  logic                overrun_q;
  logic                rd_valid_q;
  logic                accept;
  logic                writing;
  logic                last;
  logic [DATA_W-1:0]   cur_elem;
  logic [DATA_W-1:0]   ram_rdata;

  always_comb begin
    writing  = (state_q == WRITE);
    last     = (cnt_q == ADDR_W'(N - 1));
    accept   = bus.i_valid && !writing;
    cur_elem = buf_q[cnt_q*DATA_W +: DATA_W];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = WRITE;
      WRITE:   if (last)   state_d = DONE;
      DONE:    if (accept) state_d = WRITE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sum_q      <= '0;
      overrun_q  <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= 1'b1;
      if (accept) begin
        cnt_q <= '0;
        sum_q <= '0;
      end else if (writing) begin
        // cnt wraps to 0 on the last element, leaving DONE with cnt=0.
        cnt_q <= cnt_q + ADDR_W'(1);
        sum_q <= sum_q + SUM_W'(cur_elem);
      end
      if (bus.i_valid && writing) overrun_q <= 1'b1;
    end
  end

  // Shadow buffer is pure data; it is only meaningful after an accept.
  always_ff @(posedge i_clk) begin
    if (accept) buf_q <= bus.i_data;
  end

  sdp_ram_1r1w #(
    .DATA_W (DATA_W),
    .DEPTH  (N),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (i_clk),
    .we    (writing),
    .waddr (cnt_q),
    .wdata (cur_elem),
    .raddr (bus.i_probe_addr),
    .rdata (ram_rdata)
  );

  // The RAM read register has no reset; mask it until the first post-reset read.
  assign bus.o_probe_doutb = rd_valid_q ? ram_rdata : '0;
  assign bus.o_ready       = !writing;
  assign bus.o_wr_en       = writing;
  assign bus.o_wr_addr     = writing ? cnt_q : '0;
  assign bus.o_wr_data     = writing ? cur_elem : '0;
  assign bus.o_done        = (state_q == DONE);
  assign bus.o_sum         = sum_q;
  assign bus.o_overrun     = overrun_q;
  assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_softmax_out_writer.sv
// Directed bench for softmax_out_writer: write timing, sums, overrun, back-to-back and reset mid-row.
module tb_softmax_out_writer;
  import softmax_out_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  softmax_out_writer_if bus_if ();

  softmax_out_writer dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N*DATA_W-1:0] row_fill(input logic [DATA_W-1:0] v);
    logic [N*DATA_W-1:0] r;
    for (int k = 0; k < N; k++) r[k*DATA_W +: DATA_W] = v;
    return r;
  endfunction

  function automatic logic [N*DATA_W-1:0] row_ramp(input int base, input int step);
    logic [N*DATA_W-1:0] r;
    for (int k = 0; k < N; k++) r[k*DATA_W +: DATA_W] = DATA_W'(base + step * k);
    return r;
  endfunction

  task automatic pulse(input logic [N*DATA_W-1:0] row);
    @(negedge clk);
    bus_if.i_valid = 1'b1;
    bus_if.i_data  = row;
    @(negedge clk);
    bus_if.i_valid = 1'b0;
  endtask

  // Called one half-cycle after the accept edge; ends one half-cycle after the last write.
  task automatic watch_write(input logic [N*DATA_W-1:0] row, input string tag);
    for (int k = 0; k < N; k++) exp_q.push_back(row[k*DATA_W +: DATA_W]);
    for (int i = 0; i < N; i++) begin
      chk({tag, "_wr_en"}, 32'(bus_if.o_wr_en), 32'd1);
      chk({tag, "_wr_addr"}, 32'(bus_if.o_wr_addr), 32'(i));
      chk({tag, "_wr_data"}, 32'(bus_if.o_wr_data), 32'(exp_q.pop_front()));
      chk({tag, "_done_low"}, 32'(bus_if.o_done), 32'd0);
      @(negedge clk);
    end
    chk({tag, "_wr_en_end"}, 32'(bus_if.o_wr_en), 32'd0);
    chk({tag, "_done"}, 32'(bus_if.o_done), 32'd1);
    chk({tag, "_ready"}, 32'(bus_if.o_ready), 32'd1);
  endtask

  task automatic probe_sweep(input logic [N*DATA_W-1:0] row, input string tag);
    for (int a = 0; a < N; a++) begin
      bus_if.i_probe_addr = ADDR_W'(a);
      @(negedge clk);
      chk({tag, "_probe"}, 32'(bus_if.o_probe_doutb), 32'(row[a*DATA_W +: DATA_W]));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(bus_if.o_ready), 32'd1);
    chk({tag, "_done"}, 32'(bus_if.o_done), 32'd0);
    chk({tag, "_wr_en"}, 32'(bus_if.o_wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(bus_if.o_wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(bus_if.o_wr_data), 32'd0);
    chk({tag, "_sum"}, 32'(bus_if.o_sum), 32'd0);
    chk({tag, "_overrun"}, 32'(bus_if.o_overrun), 32'd0);
    chk({tag, "_probe"}, 32'(bus_if.o_probe_doutb), 32'd0);
    chk({tag, "_state"}, 32'(bus_if.dbg_state), 32'(IDLE));
  endtask

  initial begin
    logic [N*DATA_W-1:0] ramp_row;
    logic [N*DATA_W-1:0] row_a;
    logic [N*DATA_W-1:0] mixed_row;

    bus_if.i_valid      = 1'b0;
    bus_if.i_data       = '0;
    bus_if.i_probe_addr = '0;
    ramp_row = row_ramp(0, 100);
    row_a    = row_ramp(1000, 1);

    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("rst");

    // Uniform row: 32 * 2048 = 65536
    pulse(row_fill(16'd2048));
    watch_write(row_fill(16'd2048), "uni");
    chk("uni_sum", 32'(bus_if.o_sum), 32'd65536);
    bus_if.i_probe_addr = 5'd5;
    @(negedge clk);
    chk("uni_probe5", 32'(bus_if.o_probe_doutb), 32'd2048);

    // Ramp row: 100 * (0+..+31) = 49600
    pulse(ramp_row);
    watch_write(ramp_row, "ramp");
    chk("ramp_sum", 32'(bus_if.o_sum), 32'd49600);
    probe_sweep(ramp_row, "ramp");

    // Overrun: row 1000+k, sum 32000 + 496 = 32496; all-7 row dropped mid-write
    pulse(row_a);
    repeat (8) @(negedge clk);
    chk("ovr_ready_busy", 32'(bus_if.o_ready), 32'd0);
    pulse(row_fill(16'd7));
    chk("ovr_flag", 32'(bus_if.o_overrun), 32'd1);
    chk("ovr_cnt_kept", 32'(bus_if.o_wr_addr), 32'd10);
    chk("ovr_data_kept", 32'(bus_if.o_wr_data), 32'd1010);
    repeat (22) @(negedge clk);
    chk("ovr_done", 32'(bus_if.o_done), 32'd1);
    chk("ovr_sum", 32'(bus_if.o_sum), 32'd32496);
    probe_sweep(row_a, "ovr");

    // Back-to-back from DONE: 32 * 65535 = 2097120
    pulse(row_fill(16'hFFFF));
    watch_write(row_fill(16'hFFFF), "b2b");
    chk("b2b_sum", 32'(bus_if.o_sum), 32'd2097120);
    chk("b2b_overrun_sticky", 32'(bus_if.o_overrun), 32'd1);
    probe_sweep(row_fill(16'hFFFF), "b2b");

    // Reset mid-write: ramp first, then all-1 row cut off after 10 writes
    pulse(ramp_row);
    repeat (32) @(negedge clk);
    chk("mid_ramp_done", 32'(bus_if.o_done), 32'd1);
    pulse(row_fill(16'd1));
    repeat (10) @(negedge clk);
    chk("mid_cnt10", 32'(bus_if.o_wr_addr), 32'd10);
    rst = 1'b1;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    mixed_row = ramp_row;
    for (int k = 0; k < 10; k++) mixed_row[k*DATA_W +: DATA_W] = 16'd1;
    probe_sweep(mixed_row, "mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
